pb_code_lock: RTL and testbench
===============================

Name: pb_code_lock

Overview:
Input-side counterpart to the LED pattern display. Samples the raw push buttons on the divided clock o_clk, synchronises and debounces them, and decodes button presses into a code sequence. Compares the sequence against a parameterised code and reports unlock, fail and progress, which the LED display block renders.

Parameters:
CODE_LEN, 4, number of presses in the code (1..7)
CODE, 16'h8241, one-hot button per step; step i = CODE[4*i+3:4*i], so step 0 = 4'b0001
DEB_N, 3, consecutive equal synchronised samples required to accept a new button vector (1..15)
TIMEOUT, 16, o_clk cycles with no press before a partial entry is discarded (2..255)
LOCK_CYC, 8, o_clk cycles of lockout after a wrong code (1..255)

Ports:
o_clk  in  1  divided system clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
pb  in  4  raw push buttons, 1 = pressed, asynchronous to o_clk
arm  in  1  level; enables code entry (panel drives 1 when DIP selects lock mode)
unlock  out  1  level; 1 while state OPEN
fail  out  1  one-cycle pulse when a complete wrong code is entered
locked_out  out  1  level; 1 while state LOCKOUT
entry_idx  out  3  number of presses accepted in the current attempt
press_val  out  4  last accepted press vector, held until the next press
fail_cnt  out  3  count of wrong attempts, saturates at 7, cleared only on unlock or rst

Behaviour:
- Reset: asynchronous, active-high, on rst; clock o_clk. All outputs 0, FSM = IDLE, sync/debounce registers 0, timers 0. Reset mid-entry discards the attempt.
- Sync: pb passes through 2 flops. Debounce: counter restarts when the synced value changes. Debounced vector db updates once synced value has been equal for DEB_N samples. Raw-stable to db latency = 2 + DEB_N cycles (5 at default).
- Press event (press_evt): single-cycle strobe on the cycle db goes from 4'b0000 to nonzero. Release and changes between nonzero values produce no event. press_val <= db on press_evt.
- Multi-button press (db not one-hot) is a valid event that never matches any step.
- FSM:
  IDLE: arm=1 -> ENTRY (entry_idx=0, err=0).
  ENTRY: on press_evt, err |= (db != CODE step entry_idx), entry_idx++. If that press is step CODE_LEN-1: err'=0 -> OPEN; else -> LOCKOUT, fail=1 for that one cycle, fail_cnt++ (saturating). entry_idx returns to 0 on leaving ENTRY.
  ENTRY timeout: counter reset on each press_evt. If it reaches TIMEOUT with entry_idx>0 -> entry_idx=0, err=0, stay in ENTRY, no fail.
  OPEN: unlock=1, fail_cnt cleared on entry. Presses are ignored. arm=0 -> IDLE.
  LOCKOUT: locked_out=1, presses ignored, counter runs LOCK_CYC cycles, then -> ENTRY if arm=1, else IDLE.
- arm=0 in ENTRY or LOCKOUT -> IDLE immediately, attempt discarded, no fail.
- Simultaneous events:
  press_evt and timeout expiry in the same cycle: the press wins and counts.
  arm falling and final press in the same cycle: arm wins -> IDLE, no unlock, no fail.
- Widths: entry_idx compare uses a 3-bit index; fail_cnt is 3-bit saturating; timers are 8-bit.

Decomposition:
- Shared package: state enum (IDLE, ENTRY, OPEN, LOCKOUT), default code constant, timer width constant.
- Sub-module pb_debounce: 2-flop sync plus stability counter for the 4-bit vector. Outputs db and press_evt.

Test Plan:
- Reset/idle: assert rst mid-run -> all outputs 0 immediately; arm=0 with presses -> entry_idx stays 0.
- Correct code, defaults: arm=1, press 0001,0100,0010,1000, each held 6 cycles and released 6 cycles -> entry_idx 1,2,3; unlock=1 on the cycle after the 4th accepted press; fail_cnt=0.
- Wrong code: press 0001,0010,0010,1000 -> one fail pulse, locked_out=1 for 8 cycles, fail_cnt=1; presses during lockout are ignored; then back to ENTRY.
- Bounce: pb toggling every cycle for 10 cycles, then held 0001 -> exactly one press_evt, 5 cycles after the stable level; a glitch shorter than 3 samples -> no event.
- Timeout: two correct presses, then 16 idle cycles -> entry_idx=0, no fail; the full code then still unlocks.
- Corner cases:
  Multi-button 0011 as step 0 -> counted as wrong.
  arm dropped on the final press cycle -> IDLE, unlock=0, fail=0.
  Eight wrong attempts -> fail_cnt saturates at 7.

Source files
------------

// File: rtl/pb_code_lock_pkg.sv
// Shared types and constants for the push-button code lock.
package pb_code_lock_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        OPEN,
        LOCKOUT
    } lock_state_e;

    localparam int          MAX_CODE_LEN = 7;
    localparam int          CODE_W       = 4 * MAX_CODE_LEN;
    localparam logic [15:0] DEFAULT_CODE = 16'h8241;
    localparam int          TMR_W        = 8;

    // Selects the expected one-hot button vector for step idx of the code.
    function automatic logic [3:0] code_step(input logic [CODE_W-1:0] code,
                                             input logic [2:0]        idx);
        logic [3:0] step;
        step = 4'b0000;
        for (int i = 0; i < MAX_CODE_LEN; i++) begin
            if (idx == 3'(i)) begin
                step = code[4*i +: 4];
            end
        end
        return step;
    endfunction

endpackage

// File: rtl/pb_code_lock_debounce.sv
// Two-flop synchroniser plus stability counter for the 4 raw buttons.
// db follows the synchronised vector once it has been seen unchanged for
// DEB_N samples; press_evt strobes when db leaves the all-released state.
module pb_debounce #(
    parameter int DEB_N = 3
) (
    input  logic       o_clk,
    input  logic       rst,
    input  logic [3:0] pb,
    output logic [3:0] db,
    output logic       press_evt
);

    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic [3:0] last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] db_q, db_d;
    logic       evt_q, evt_d;

    // Next-state: restart the stability count on any change, accept when stable.
    always_comb begin
        sync1_d = pb;
        sync2_d = sync1_q;
        last_d  = sync2_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        if (sync2_q != last_q) begin
            cnt_d = 4'd1;
        end else if (cnt_q != 4'hF) begin
            cnt_d = cnt_q + 4'd1;
        end
        if (cnt_d >= 4'(DEB_N)) begin
            db_d = sync2_q;
        end
        evt_d = (db_q == 4'b0000) && (db_d != 4'b0000);
    end

    // Register bank for synchroniser, counter, debounced vector and strobe.
    always_ff @(posedge o_clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
            last_q  <= 4'b0000;
            cnt_q   <= 4'd0;
            db_q    <= 4'b0000;
            evt_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            evt_q   <= evt_d;
        end
    end

    assign db        = db_q;
    assign press_evt = evt_q;

endmodule

// File: rtl/pb_code_lock.sv
// Code lock: compares debounced button presses against a stored code and
// reports unlock, a fail pulse, lockout and entry progress.
module pb_code_lock
    import pb_code_lock_pkg::*;
#(
    parameter int                CODE_LEN = 4,
    parameter logic [CODE_W-1:0] CODE     = CODE_W'(DEFAULT_CODE),
    parameter int                DEB_N    = 3,
    parameter int                TIMEOUT  = 16,
    parameter int                LOCK_CYC = 8
) (
    input  logic       o_clk,
    input  logic       rst,
    input  logic [3:0] pb,
    input  logic       arm,
    output logic       unlock,
    output logic       fail,
    output logic       locked_out,
    output logic [2:0] entry_idx,
    output logic [3:0] press_val,
    output logic [2:0] fail_cnt
);

    localparam logic [2:0]       LAST_IDX     = 3'(CODE_LEN - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST    = TMR_W'(LOCK_CYC - 1);

    logic [3:0]       db;
    logic             press_evt;
    logic             press_err;

    lock_state_e      state_q, state_d;
    logic [2:0]       entry_idx_q, entry_idx_d;
    logic             err_q, err_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             fail_q, fail_d;
    logic [2:0]       fail_cnt_q, fail_cnt_d;
    logic [3:0]       press_val_q, press_val_d;

    pb_debounce #(
        .DEB_N(DEB_N)
    ) u_debounce (
        .o_clk    (o_clk),
        .rst      (rst),
        .pb       (pb),
        .db       (db),
        .press_evt(press_evt)
    );

    // Next-state logic: arm loss dominates, then presses, then timers.
    always_comb begin
        state_d     = state_q;
        entry_idx_d = entry_idx_q;
        err_d       = err_q;
        tmr_d       = tmr_q;
        fail_d      = 1'b0;
        fail_cnt_d  = fail_cnt_q;
        press_val_d = press_val_q;
        press_err   = (db != code_step(CODE, entry_idx_q));

        if (press_evt) begin
            press_val_d = db;
        end

        case (state_q)
            IDLE: begin
                entry_idx_d = 3'd0;
                err_d       = 1'b0;
                tmr_d       = '0;
                if (arm) begin
                    state_d = ENTRY;
                end
            end
            ENTRY: begin
                if (!arm) begin
                    state_d     = IDLE;
                    entry_idx_d = 3'd0;
                    err_d       = 1'b0;
                    tmr_d       = '0;
                end else if (press_evt) begin
                    tmr_d = '0;
                    if (entry_idx_q == LAST_IDX) begin
                        entry_idx_d = 3'd0;
                        err_d       = 1'b0;
                        if (err_q || press_err) begin
                            state_d = LOCKOUT;
                            fail_d  = 1'b1;
                            if (fail_cnt_q != 3'd7) begin
                                fail_cnt_d = fail_cnt_q + 3'd1;
                            end
                        end else begin
                            state_d    = OPEN;
                            fail_cnt_d = 3'd0;
                        end
                    end else begin
                        entry_idx_d = entry_idx_q + 3'd1;
                        err_d       = err_q | press_err;
                    end
                end else if (entry_idx_q != 3'd0) begin
                    if (tmr_q == TIMEOUT_LAST) begin
                        entry_idx_d = 3'd0;
                        err_d       = 1'b0;
                        tmr_d       = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end else begin
                    tmr_d = '0;
                end
            end
            OPEN: begin
                tmr_d = '0;
                if (!arm) begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (!arm) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else if (tmr_q == LOCK_LAST) begin
                    state_d = ENTRY;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge o_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            entry_idx_q <= 3'd0;
            err_q       <= 1'b0;
            tmr_q       <= '0;
            fail_q      <= 1'b0;
            fail_cnt_q  <= 3'd0;
            press_val_q <= 4'b0000;
        end else begin
            state_q     <= state_d;
            entry_idx_q <= entry_idx_d;
            err_q       <= err_d;
            tmr_q       <= tmr_d;
            fail_q      <= fail_d;
            fail_cnt_q  <= fail_cnt_d;
            press_val_q <= press_val_d;
        end
    end

    assign unlock     = (state_q == OPEN);
    assign locked_out = (state_q == LOCKOUT);
    assign fail       = fail_q;
    assign entry_idx  = entry_idx_q;
    assign press_val  = press_val_q;
    assign fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_pb_code_lock.sv
// Directed testbench for pb_code_lock with hand-computed expectations.
module tb_pb_code_lock;

    logic       o_clk = 1'b0;
    logic       rst;
    logic [3:0] pb;
    logic       arm;
    logic       unlock;
    logic       fail;
    logic       locked_out;
    logic [2:0] entry_idx;
    logic [3:0] press_val;
    logic [2:0] fail_cnt;

    int checks      = 0;
    int errors      = 0;
    int fail_pulses = 0;
    int evt_count   = 0;
    int lock_cycles = 0;
    int fails0;
    int evt0;
    int first_n;

    pb_code_lock dut (
        .o_clk     (o_clk),
        .rst       (rst),
        .pb        (pb),
        .arm       (arm),
        .unlock    (unlock),
        .fail      (fail),
        .locked_out(locked_out),
        .entry_idx (entry_idx),
        .press_val (press_val),
        .fail_cnt  (fail_cnt)
    );

    // Free-running 10 ns clock.
    always #5 o_clk = ~o_clk;

    // Event monitors sampled on the falling edge.
    always @(negedge o_clk) begin
        if (fail) fail_pulses++;
        if (locked_out) lock_cycles++;
        if (dut.u_debounce.press_evt) evt_count++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge o_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] vec, input int cycles);
        pb = vec;
        tick(cycles);
    endtask

    task automatic pressStep(input logic [3:0] vec);
        applyStimulus(vec, 6);
        applyStimulus(4'b0000, 6);
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        arm = 1'b0;
        pb  = 4'b0000;
        tick(3);
        checkOutput("rst_unlock", unlock, 0);
        checkOutput("rst_entry_idx", entry_idx, 0);
        checkOutput("rst_fail_cnt", fail_cnt, 0);
        rst = 1'b0;
        tick(2);

        // Disarmed presses do not advance entry.
        pressStep(4'b0001);
        checkOutput("idle_entry_idx", entry_idx, 0);
        checkOutput("idle_press_val", press_val, 1);

        // Correct code.
        arm = 1'b1;
        tick(2);
        pressStep(4'b0001);
        checkOutput("ok_idx1", entry_idx, 1);
        pressStep(4'b0100);
        checkOutput("ok_idx2", entry_idx, 2);
        pressStep(4'b0010);
        checkOutput("ok_idx3", entry_idx, 3);
        pb = 4'b1000;
        tick(5);
        checkOutput("ok_evt", dut.u_debounce.press_evt, 1);
        checkOutput("ok_unlock_before", unlock, 0);
        tick(1);
        checkOutput("ok_unlock", unlock, 1);
        checkOutput("ok_idx_reset", entry_idx, 0);
        checkOutput("ok_fail_cnt", fail_cnt, 0);
        applyStimulus(4'b0000, 6);
        pressStep(4'b0001);
        checkOutput("open_ignores", entry_idx, 0);
        checkOutput("open_hold", unlock, 1);
        arm = 1'b0;
        tick(2);
        checkOutput("disarm_unlock", unlock, 0);

        // Wrong code with a press attempted during lockout.
        arm = 1'b1;
        tick(2);
        fails0 = fail_pulses;
        pressStep(4'b0001);
        pressStep(4'b0010);
        pressStep(4'b0010);
        checkOutput("bad_idx3", entry_idx, 3);
        lock_cycles = 0;
        pb = 4'b1000;
        tick(3);
        pb = 4'b0000;
        tick(2);
        checkOutput("bad_fail_early", fail, 0);
        tick(1);
        checkOutput("bad_fail", fail, 1);
        checkOutput("bad_locked", locked_out, 1);
        checkOutput("bad_fail_cnt", fail_cnt, 1);
        tick(1);
        pb = 4'b0001;
        checkOutput("bad_fail_pulse", fail, 0);
        tick(6);
        checkOutput("lock_still", locked_out, 1);
        checkOutput("lock_ignores", entry_idx, 0);
        checkOutput("lock_press_val", press_val, 1);
        tick(1);
        checkOutput("lock_done", locked_out, 0);
        checkOutput("lock_cycles", lock_cycles, 8);
        checkOutput("bad_pulses", fail_pulses - fails0, 1);
        applyStimulus(4'b0000, 6);
        pressStep(4'b0001);
        checkOutput("reentry_idx", entry_idx, 1);
        tick(20);
        checkOutput("reentry_timeout", entry_idx, 0);

        // Timeout discards a partial entry, then the full code still unlocks.
        fails0 = fail_pulses;
        pressStep(4'b0001);
        pressStep(4'b0100);
        checkOutput("to_idx2", entry_idx, 2);
        tick(4);
        checkOutput("to_before", entry_idx, 2);
        tick(8);
        checkOutput("to_after", entry_idx, 0);
        checkOutput("to_no_fail", fail_pulses - fails0, 0);
        pressStep(4'b0001);
        pressStep(4'b0100);
        pressStep(4'b0010);
        pressStep(4'b1000);
        checkOutput("to_unlock", unlock, 1);
        checkOutput("to_fail_cnt_clr", fail_cnt, 0);
        arm = 1'b0;
        tick(2);

        // Multi-button press as step 0 counts as wrong.
        arm = 1'b1;
        tick(2);
        pressStep(4'b0011);
        checkOutput("multi_idx", entry_idx, 1);
        checkOutput("multi_val", press_val, 3);
        pressStep(4'b0100);
        pressStep(4'b0010);
        applyStimulus(4'b1000, 6);
        checkOutput("multi_locked", locked_out, 1);
        checkOutput("multi_unlock", unlock, 0);
        checkOutput("multi_fail_cnt", fail_cnt, 1);
        applyStimulus(4'b0000, 10);
        checkOutput("multi_unlocked", locked_out, 0);

        // arm drops in the same cycle as the final press.
        fails0 = fail_pulses;
        pressStep(4'b0001);
        pressStep(4'b0100);
        pressStep(4'b0010);
        pb = 4'b1000;
        tick(5);
        arm = 1'b0;
        tick(1);
        checkOutput("drop_unlock", unlock, 0);
        checkOutput("drop_locked", locked_out, 0);
        checkOutput("drop_idx", entry_idx, 0);
        applyStimulus(4'b0000, 6);
        checkOutput("drop_no_fail", fail_pulses - fails0, 0);
        checkOutput("drop_fail_cnt", fail_cnt, 1);

        // Repeated wrong attempts saturate the fail counter.
        arm = 1'b1;
        tick(2);
        for (int n = 0; n < 7; n++) begin
            for (int s = 0; s < 4; s++) begin
                pressStep(4'b1000);
            end
            tick(4);
            checkOutput("sat_fail_cnt", fail_cnt, (n + 2 > 7) ? 7 : n + 2);
        end
        arm = 1'b0;
        tick(2);

        // Bouncing input followed by a stable press yields one event.
        pb = 4'b0000;
        tick(8);
        evt0 = evt_count;
        for (int i = 0; i < 10; i++) begin
            pb = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            tick(1);
        end
        pb = 4'b0001;
        first_n = 0;
        for (int n = 1; n <= 8; n++) begin
            tick(1);
            if (first_n == 0 && dut.u_debounce.press_evt) first_n = n;
        end
        checkOutput("bounce_latency", first_n, 5);
        applyStimulus(4'b0000, 10);
        checkOutput("bounce_evts", evt_count - evt0, 1);

        // Short glitch produces no event.
        evt0 = evt_count;
        applyStimulus(4'b0001, 2);
        applyStimulus(4'b0000, 10);
        checkOutput("glitch_evts", evt_count - evt0, 0);

        // Asynchronous reset mid-entry clears everything at once.
        arm = 1'b1;
        tick(2);
        pressStep(4'b0001);
        pressStep(4'b0100);
        checkOutput("pre_rst_idx", entry_idx, 2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_idx", entry_idx, 0);
        checkOutput("async_rst_fail_cnt", fail_cnt, 0);
        checkOutput("async_rst_val", press_val, 0);
        checkOutput("async_rst_lock", locked_out, 0);
        arm = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
        checkOutput("post_rst_idx", entry_idx, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
